// File: rtl/mycpu_pkg.sv
// Shared CPU definitions: bus widths and field offsets of the fetch->decode
// bus and the branch bus.
//   fs_to_ds_bus = {adef, pc[31:0], inst[31:0]}
//   br_bus       = {br_taken, br_target[31:0]}
package mycpu_pkg;
  localparam int FS_TO_DS_BUS_WD = 65;
  localparam int BR_BUS_WD       = 33;

  localparam int FS_INST_LSB = 0;
  localparam int FS_PC_LSB   = 32;
  localparam int FS_ADEF_BIT = 64;

  localparam int BR_TARGET_LSB = 0;
  localparam int BR_TAKEN_BIT  = 32;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, arbitrary DEPTH >= 1 (pointers wrap explicitly).
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   i_push/i_din  write strobe and data (ignored when full)
//   i_pop         read strobe (ignored when empty); o_dout shows the head
//   i_flush       empties the FIFO, wins over push/pop
//   o_full, o_empty, o_count  occupancy
module sync_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 4,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd, r_wr;
  logic [CW-1:0]    r_cnt;
  logic             w_do_push, w_do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full    = (r_cnt == CW'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign o_count   = r_cnt;
  assign o_dout    = r_mem[r_rd];
  assign w_do_push = i_push & ~o_full & ~i_flush;
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= ptr_inc(r_wr);
      if (w_do_pop)  r_rd <= ptr_inc(r_rd);
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage is not reset; head is only meaningful when !o_empty.
  always_ff @(posedge clk) begin
    if (!reset && w_do_push) r_mem[r_wr] <= i_din;
  end
endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage with a decoupling instruction queue.
// Issues in-order SRAM-like fetches from pc_q, buffers returned instructions
// for decode, and handles branch/exception/ertn redirects by flushing the
// queue and discarding responses that were already in flight.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   ds_allowin                    decode accepts the queue head
//   fs_to_ds_valid/fs_to_ds_bus   queue head {adef, pc, inst}
//   br_bus                        {br_taken, br_target}
//   excp_flush/ertn_flush         redirect to csr_eentry / csr_era
//   inst_req/inst_addr            fetch request, address = pc_q
//   inst_addr_ok/inst_data_ok/inst_rdata  slave handshakes, in-order data
import mycpu_pkg::*;

module if_fetch_queue #(
  parameter int          IQ_DEPTH  = 4,
  parameter int          MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = 32'h1c000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ds_allowin,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  input  logic                       excp_flush,
  input  logic                       ertn_flush,
  input  logic [31:0]                csr_eentry,
  input  logic [31:0]                csr_era,
  output logic                       inst_req,
  output logic [31:0]                inst_addr,
  input  logic                       inst_addr_ok,
  input  logic                       inst_data_ok,
  input  logic [31:0]                inst_rdata
);
  localparam int OW  = $clog2(MAX_OUTST + 1);
  localparam int IQC = $clog2(IQ_DEPTH + 1);
  localparam int PQC = $clog2(MAX_OUTST + 1);

  logic [31:0]   r_pc;
  logic [OW-1:0] r_outst;
  logic [OW-1:0] r_discard;
  logic          r_adef_stop;

  logic                       w_br_taken, w_redirect, w_misalign, w_credit;
  logic                       w_addr_hs, w_discard, w_resp_push, w_adef_push;
  logic                       w_iq_push, w_iq_pop, w_iq_empty, w_iq_full;
  logic [31:0]                w_target, w_pend_pc;
  logic [FS_TO_DS_BUS_WD-1:0] w_iq_din, w_iq_dout;
  logic [IQC-1:0]             w_iq_cnt;
  logic                       w_pend_full, w_pend_empty;
  logic [PQC-1:0]             w_pend_cnt;
  logic                       w_unused;

  assign w_br_taken = br_bus[BR_TAKEN_BIT];
  assign w_redirect = excp_flush | ertn_flush | w_br_taken;
  assign w_target   = excp_flush ? csr_eentry :
                      ertn_flush ? csr_era    : br_bus[BR_TARGET_LSB +: 32];
  assign w_misalign = (r_pc[1:0] != 2'b00);

  // Every in-flight request reserves a queue slot, so a response can always
  // be written and the queue never overflows.
  assign w_credit = (int'(r_outst) + int'(w_iq_cnt)) < IQ_DEPTH;

  assign inst_req  = ~reset & ~w_redirect & ~r_adef_stop & ~w_misalign &
                     (int'(r_outst) < MAX_OUTST) & w_credit;
  assign inst_addr = r_pc;
  assign w_addr_hs = inst_req & inst_addr_ok;

  // Misaligned PC: emit one adef entry once the bus is idle, then stall.
  assign w_adef_push = w_misalign & ~w_redirect & ~r_adef_stop &
                       (r_outst == '0) & w_credit;

  // Responses belonging to a squashed path (or arriving in the redirect
  // cycle itself) are dropped but still retire their pending PC.
  assign w_discard   = inst_data_ok & (w_redirect | (r_discard != '0));
  assign w_resp_push = inst_data_ok & ~w_discard;

  assign w_iq_push = w_resp_push | w_adef_push;
  assign w_iq_pop  = fs_to_ds_valid & ds_allowin & ~w_redirect;

  always_comb begin
    w_iq_din = '0;
    if (w_adef_push) begin
      w_iq_din[FS_ADEF_BIT]        = 1'b1;
      w_iq_din[FS_PC_LSB +: 32]    = r_pc;
    end else begin
      w_iq_din[FS_PC_LSB +: 32]    = w_pend_pc;
      w_iq_din[FS_INST_LSB +: 32]  = inst_rdata;
    end
  end

  assign fs_to_ds_valid = ~w_iq_empty;
  assign fs_to_ds_bus   = w_iq_empty ? '0 : w_iq_dout;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_outst     <= '0;
      r_discard   <= '0;
      r_adef_stop <= 1'b0;
    end else begin
      if (w_redirect) begin
        r_pc        <= w_target;
        r_adef_stop <= 1'b0;
        r_discard   <= r_outst - OW'(inst_data_ok);
      end else begin
        if (w_addr_hs)                      r_pc        <= r_pc + 32'd4;
        if (w_adef_push)                    r_adef_stop <= 1'b1;
        if (inst_data_ok && r_discard != '0) r_discard  <= r_discard - 1'b1;
      end
      case ({w_addr_hs, inst_data_ok})
        2'b10:   r_outst <= r_outst + 1'b1;
        2'b01:   r_outst <= r_outst - 1'b1;
        default: r_outst <= r_outst;
      endcase
    end
  end

  sync_fifo #(.WIDTH(FS_TO_DS_BUS_WD), .DEPTH(IQ_DEPTH)) u_iq (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_iq_push),
    .i_pop   (w_iq_pop),
    .i_flush (w_redirect),
    .i_din   (w_iq_din),
    .o_dout  (w_iq_dout),
    .o_full  (w_iq_full),
    .o_empty (w_iq_empty),
    .o_count (w_iq_cnt)
  );

  // PC of each accepted request, retired in order by data_ok. Never flushed:
  // discarded responses still have to pop their entry.
  sync_fifo #(.WIDTH(32), .DEPTH(MAX_OUTST)) u_pend (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_addr_hs),
    .i_pop   (inst_data_ok),
    .i_flush (1'b0),
    .i_din   (r_pc),
    .o_dout  (w_pend_pc),
    .o_full  (w_pend_full),
    .o_empty (w_pend_empty),
    .o_count (w_pend_cnt)
  );

  assign w_unused = ^{w_iq_full, w_pend_full, w_pend_empty, w_pend_cnt};
endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;
  localparam int          IQ_DEPTH  = 4;
  localparam int          MAX_OUTST = 2;
  localparam logic [31:0] RESET_PC  = 32'h1c000000;

  logic        clk, reset, ds_allowin, fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;
  logic [32:0] br_bus;
  logic        excp_flush, ertn_flush;
  logic [31:0] csr_eentry, csr_era;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;

  if_fetch_queue #(.IQ_DEPTH(IQ_DEPTH), .MAX_OUTST(MAX_OUTST), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .ds_allowin(ds_allowin),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .br_bus(br_bus), .excp_flush(excp_flush), .ertn_flush(ertn_flush),
    .csr_eentry(csr_eentry), .csr_era(csr_era),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a5ac3c3;
  endfunction

  // Reference model: architectural fetch stream. After a redirect to T the
  // decoder must see T, T+4, ... ; a misaligned T yields one adef entry only.
  logic [64:0] exp_q[$];
  logic [31:0] gen_pc;
  bit          gen_run;

  function automatic void sb_redirect(input logic [31:0] t);
    exp_q.delete();
    if (t[1:0] != 2'b00) begin
      exp_q.push_back({1'b1, t, 32'h0});
      gen_run = 1'b0;
    end else begin
      gen_pc  = t;
      gen_run = 1'b1;
    end
  endfunction

  function automatic void sb_topup();
    while (gen_run && exp_q.size() < 16) begin
      exp_q.push_back({1'b0, gen_pc, rdata_of(gen_pc)});
      gen_pc = gen_pc + 32'd4;
    end
  endfunction

  // Slave: in-order responses, each with its own random latency.
  logic [31:0] sl_addr[$];
  int          sl_due[$];
  int          cyc = 0;
  int          aok_pct = 100, allow_pct = 100, lat_min = 1, lat_max = 1;
  bit          nx_excp = 0, nx_ertn = 0, nx_br = 0;
  logic [31:0] nx_brt = '0;
  int          n_acc = 0, n_del = 0;
  bit          any_req = 0, mark_arm = 0, mark_seen = 0;
  logic [64:0] mark_bus = '0;

  task automatic step();
    logic [31:0] tgt;
    @(negedge clk);
    cyc++;
    reset        = 1'b0;
    inst_addr_ok = ($urandom_range(99) < aok_pct);
    if (sl_addr.size() > 0 && sl_due[0] <= cyc) begin
      inst_data_ok = 1'b1;
      inst_rdata   = rdata_of(sl_addr[0]);
    end else begin
      inst_data_ok = 1'b0;
      inst_rdata   = $urandom;
    end
    ds_allowin = ($urandom_range(99) < allow_pct);
    excp_flush = nx_excp;
    ertn_flush = nx_ertn;
    br_bus     = {nx_br, nx_br ? nx_brt : 32'($urandom)};
    nx_excp = 0; nx_ertn = 0; nx_br = 0;
    #1;
    any_req |= inst_req;
    if (inst_data_ok) begin
      void'(sl_addr.pop_front());
      void'(sl_due.pop_front());
    end
    if (inst_req && inst_addr_ok) begin
      sl_addr.push_back(inst_addr);
      sl_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
      n_acc++;
    end
    if (excp_flush || ertn_flush || br_bus[32]) begin
      tgt = excp_flush ? csr_eentry : (ertn_flush ? csr_era : br_bus[31:0]);
      sb_redirect(tgt);
    end
    sb_topup();
  endtask

  task automatic redir_step(input bit e, input bit r, input bit b, input logic [31:0] brt);
    nx_excp = e; nx_ertn = r; nx_br = b; nx_brt = brt;
    step();
    mark_arm = 1; mark_seen = 0; mark_bus = '0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      reset = 1'b1; ds_allowin = 1'b0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
      excp_flush = 1'b0; ertn_flush = 1'b0; br_bus = '0;
      #1;
      if (i == 1) begin
        chk("rst_valid",    65'(fs_to_ds_valid), 65'(0));
        chk("rst_inst_req", 65'(inst_req),       65'(0));
        chk("rst_addr",     65'(inst_addr),      65'(RESET_PC));
        chk("rst_bus",      fs_to_ds_bus,        65'(0));
      end
    end
    sl_addr.delete(); sl_due.delete();
    n_acc = 0; n_del = 0;
    sb_redirect(RESET_PC);
    sb_topup();
    mark_arm = 1; mark_seen = 0; mark_bus = '0;
  endtask

  // Monitor: consumes deliveries and checks protocol invariants.
  logic        p_req = 0, p_aok = 0, m_redir;
  logic [31:0] p_addr = '0;
  logic [64:0] m_exp;

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        p_req = 1'b0;
      end else begin
        m_redir = excp_flush | ertn_flush | br_bus[32];
        if (p_req && !p_aok && !m_redir) begin
          chk("addr_hold_req",  65'(inst_req),  65'(1));
          chk("addr_hold_addr", 65'(inst_addr), 65'(p_addr));
        end
        if (fs_to_ds_valid && ds_allowin && !m_redir) begin
          n_del++;
          if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL deliver_unexpected: got %h expected no entry", fs_to_ds_bus);
          end else begin
            m_exp = exp_q.pop_front();
            chk("deliver", fs_to_ds_bus, m_exp);
          end
          if (mark_arm) begin
            mark_bus = fs_to_ds_bus; mark_arm = 0; mark_seen = 1;
          end
        end
        chk("outst_max", 65'(sl_addr.size() <= MAX_OUTST), 65'(1));
        p_req = inst_req; p_aok = inst_addr_ok; p_addr = inst_addr;
      end
    end
  end

  function automatic logic [31:0] rand_tgt();
    int r;
    r = int'($urandom_range(99));
    if (r < 3)  return 32'hfffffff8;
    if (r < 10) return 32'h1c000000 + ($urandom_range(4095) << 2) + $urandom_range(3, 1);
    return 32'h1c000000 + ($urandom_range(4095) << 2);
  endfunction

  initial begin
    int d0, nbr, guard, t;
    bit got;
    reset = 1'b1; ds_allowin = 0; br_bus = '0; excp_flush = 0; ertn_flush = 0;
    csr_eentry = '0; csr_era = '0; inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = '0;

    // Reset and steady-state streaming
    do_reset();
    run(9);
    d0 = n_del;
    run(20);
    chk("steady_rate", 65'(n_del - d0), 65'(20));
    chk("first_pc", mark_bus, {1'b0, RESET_PC, rdata_of(RESET_PC)});

    // Decode stall fills the queue exactly and stops fetching
    allow_pct = 0;
    run(10);
    chk("stall_queued", 65'(n_acc - n_del - sl_addr.size()), 65'(IQ_DEPTH));
    chk("stall_req", 65'(inst_req), 65'(0));
    allow_pct = 100;
    run(20);

    // Branch with two requests in flight
    lat_min = 3; lat_max = 3;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      step();
      if (sl_addr.size() == MAX_OUTST) got = 1;
    end
    chk("br_outst_reached", 65'(got), 65'(1));
    redir_step(0, 0, 1, 32'h1c000100);
    run(20);
    chk("br_next_pc", 65'(mark_bus[63:32]), 65'(32'h1c000100));

    // Exception beats a same-cycle branch
    csr_eentry = 32'h1c008000;
    redir_step(1, 0, 1, 32'h1c000200);
    run(20);
    chk("excp_next_pc", 65'(mark_bus[63:32]), 65'(32'h1c008000));

    // Misaligned target: one adef entry, then no fetch until ertn
    redir_step(0, 0, 1, 32'h1c000102);
    any_req = 0;
    run(15);
    chk("adef_entry", mark_bus, {1'b1, 32'h1c000102, 32'h0});
    chk("adef_noreq", 65'(any_req), 65'(0));
    csr_era = 32'h1c000010;
    redir_step(0, 1, 0, 32'h0);
    run(20);
    chk("ertn_next_pc", 65'(mark_bus[63:32]), 65'(32'h1c000010));

    // Reset in the middle of random traffic
    aok_pct = 60; lat_min = 1; lat_max = 5; allow_pct = 70;
    run(30);
    do_reset();
    run(40);
    chk("midrst_first_pc", 65'(mark_bus[63:32]), 65'(RESET_PC));

    // Random redirects against the reference stream
    nbr = 0; guard = 0; d0 = n_del;
    while (nbr < 1000 && guard < 60000) begin
      guard++;
      if ($urandom_range(99) < 8) begin
        csr_eentry = rand_tgt(); csr_era = rand_tgt();
        t = int'($urandom_range(9));
        case (t)
          0:       redir_step(1, 0, 0, rand_tgt());
          1:       redir_step(1, 0, 1, rand_tgt());
          2:       redir_step(0, 1, 0, rand_tgt());
          3:       redir_step(0, 1, 1, rand_tgt());
          4:       redir_step(1, 1, 0, rand_tgt());
          default: redir_step(0, 0, 1, rand_tgt());
        endcase
        nbr++;
      end else begin
        step();
      end
    end
    chk("random_branches", 65'(nbr), 65'(1000));
    chk("random_progress", 65'((n_del - d0) > 500), 65'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/if_fetch_queue.md
IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 SHALL have parameter IQ_DEPTH, default 4, instruction-queue entries (power of two, >=2).
REQ-002 SHALL have parameter MAX_OUTST, default 2, maximum accepted-but-unanswered fetch requests (1..IQ_DEPTH).
REQ-003 SHALL have parameter RESET_PC, default 32'h1c000000, first fetch address after reset.
REQ-004 SHALL have port clk  in  1  clock; the clock is clk.
REQ-005 SHALL have port reset  in  1  reset; reset is synchronous, active-high.
REQ-006 SHALL have ports ds_allowin in 1 (decode accepts); fs_to_ds_valid out 1 (queue head valid); fs_to_ds_bus out FS_TO_DS_BUS_WD=65 {adef, pc[31:0], inst[31:0]}.
REQ-007 SHALL have port br_bus  in  BR_BUS_WD=33  {br_taken, br_target[31:0]}.
REQ-008 SHALL have ports excp_flush in 1, ertn_flush in 1, csr_eentry in 32, csr_era in 32.
REQ-009 SHALL have ports inst_req out 1, inst_addr out 32, inst_addr_ok in 1, inst_data_ok in 1, inst_rdata in 32 (SRAM-like, in-order responses).

Function
REQ-010 SHALL hold fetch PC pc_q; redirect = excp_flush | ertn_flush | br_taken; target priority csr_eentry > csr_era > br_target.
REQ-011 SHALL, in a redirect cycle, load pc_q <= target, clear the instruction queue and the adef-stop flag, and force inst_req=0.
REQ-012 SHALL track outst (0..MAX_OUTST): +1 on inst_req&inst_addr_ok, -1 on inst_data_ok, both same cycle = unchanged.
REQ-013 SHALL drive inst_req=1 iff !reset, !redirect, !adef_stop, pc_q[1:0]==0, outst<MAX_OUTST, and outst+iq_count < IQ_DEPTH (credit).
REQ-014 SHALL drive inst_addr=pc_q; on inst_req&inst_addr_ok SHALL set pc_q <= pc_q+4 (mod 2^32) and push pc_q into the pending-PC queue.
REQ-015 SHALL keep inst_addr stable while inst_req=1 and inst_addr_ok=0.
REQ-016 SHALL maintain discard_cnt; on redirect SHALL set discard_cnt <= outst - inst_data_ok (all still-in-flight responses, including previously discarded ones).
REQ-017 SHALL, on inst_data_ok with discard_cnt>0, drop the response, pop pending-PC queue, decrement discard_cnt; otherwise push {0, pending_pc, inst_rdata} into the instruction queue.
REQ-018 SHALL, when pc_q[1:0]!=0, !redirect, outst==0 and credit available, push {1, pc_q, 32'h0} into the queue without a bus request and set adef_stop until the next redirect.
REQ-019 SHALL assert fs_to_ds_valid iff queue non-empty and drive fs_to_ds_bus from the head combinationally; pop on fs_to_ds_valid & ds_allowin.
REQ-020 SHALL allow simultaneous push and pop (count unchanged); full queue SHALL never be pushed (guaranteed by REQ-013 credit).
REQ-021 SHALL, in a redirect cycle, ignore pop and non-discarded push (flush wins); a data_ok in that cycle is discarded.

Reset
REQ-022 SHALL on reset set pc_q=RESET_PC, outst=0, discard_cnt=0, adef_stop=0, both queues empty; outputs fs_to_ds_valid=0, inst_req=0, inst_addr=RESET_PC, fs_to_ds_bus=0.
REQ-023 SHALL, on reset mid-operation, abandon in-flight responses; bench slave is reset together.

Structure
REQ-024 SHALL place FS_TO_DS_BUS_WD, BR_BUS_WD and the bus field offsets in the shared mycpu package/header.
REQ-025 SHALL use one sub-module sync_fifo (params WIDTH, DEPTH; push/pop/flush/full/empty/count), instantiated for the instruction queue (65 bits x IQ_DEPTH) and pending-PC queue (32 bits x MAX_OUTST).

Verification
REQ-026 Reset release, slave addr_ok/data_ok=1 next cycle, ds_allowin=1 -> decode receives pc 0x1c000000, 0x1c000004, 0x1c000008 in order, one per cycle steady state.
REQ-027 ds_allowin=0 for 10 cycles -> exactly IQ_DEPTH entries queued, inst_req deasserts, no entry lost or duplicated after release.
REQ-028 br_taken target 0x1c000100 with 2 outstanding -> both stale responses discarded, next delivered pc 0x1c000100.
REQ-029 excp_flush and br_taken same cycle, csr_eentry 0x1c008000 -> next delivered pc 0x1c008000.
REQ-030 br_target 0x1c000102 -> one entry {adef=1, pc 0x1c000102}, no inst_req until ertn_flush to csr_era 0x1c000010, then fetch resumes there.
REQ-031 data_ok latency randomised 1-5 cycles, random ds_allowin, 1000 branches -> delivered PC stream matches reference model, outst never exceeds MAX_OUTST.
